hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard that replaces pairwise rd/rs comparison with per-register pending-write tracking for a LANES-wide in-order issue stage. It sits between decode and execute. Each cycle it accepts or holds each issue lane, and for every accepted source operand it produces a forwarding select and a producing-lane index for the execute-stage operand muxes. Variable producer latency covers ALU, load and multi-cycle ops uniformly, and replaces the fixed load-use stall rule.

## Interface
Parameters:
- AWIDTH, 5: register address width; NREGS = 2**AWIDTH entries; register 0 is never tracked.
- LANES, 2: issue lanes, minimum 1; LANE_W = max(1, $clog2(LANES)).
- MAX_LAT, 3: maximum producer latency in cycles; LAT_W = $clog2(MAX_LAT+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  kill all pending (WAIT) entries and suppress this cycle's issue.
- i_issue_valid  in  LANES  lane k holds an instruction.
- i_issue_regwrite  in  LANES  lane k writes rd.
- i_issue_rd  in  LANES*AWIDTH  destination per lane.
- i_issue_lat  in  LANES*LAT_W  cycles until the result reaches EX/MEM; 0 is treated as 1; values above MAX_LAT are clamped to MAX_LAT.
- i_src_addr  in  LANES*2*AWIDTH  rs1 and rs2 per lane, rs1 in the low field.
- o_ack  out  LANES  lane k accepted this cycle.
- o_stall  out  1  at least one valid lane not acked.
- o_fwd_sel  out  LANES*2*2  per source: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB.
- o_fwd_lane  out  LANES*2*LANE_W  producing lane for sel 1 or 2; 0 when sel is 0.

## Operation
- Each entry r (1..NREGS-1) holds state[1:0] (REG, WAIT, EXMEM, MEMWB), cnt[LAT_W-1:0] and lane[LANE_W-1:0].
- Per-cycle state progression:
  - WAIT with cnt > 1: cnt decrements.
  - WAIT with cnt == 1: go to EXMEM.
  - EXMEM: go to MEMWB.
  - MEMWB: go to REG.
  - REG: hold.
- Accept lane k with regwrite=1 and rd != 0: entry rd is loaded with lane = k.
  - Effective latency 1: state EXMEM.
  - Otherwise: state WAIT, cnt = lat-1.
  - The load overrides normal progression for that entry (newer write wins on WAW).
- Same rd accepted on several lanes in one cycle: the highest lane index wins.
- Source readiness:
  - A source at address 0 is always ready, with sel 0.
  - Otherwise the source is not ready if its entry is WAIT.
  - It is also not ready if it matches the rd of an acked lower lane in the same cycle that has regwrite=1. There is no same-cycle intra-bundle forwarding.
- Otherwise sel comes from the entry state: REG gives 0, EXMEM gives 1, MEMWB gives 2. o_fwd_lane = entry lane.
- Ack chain: blocked[0] = i_flush; blocked[k] = blocked[k-1] | (valid[k-1] & ~ack[k-1]). ack[k] = valid[k] & ~blocked[k] & both sources ready.
- A lane with valid=0 neither blocks nor acks.
- o_stall = |(valid & ~ack) when i_flush is 0, and 0 when i_flush is 1.
- i_flush: at the next edge, every WAIT entry goes to REG and every other entry progresses normally. No lane acks in a flush cycle.

## Timing
- o_ack, o_stall, o_fwd_sel and o_fwd_lane are combinational from the inputs and current entry state. There is no registered path from input to output.
- Entry state updates on the rising edge of i_clk.
- ALU producer (lat 1) issued in cycle t: a dependent source sees sel 1 in t+1, sel 2 in t+2, sel 0 from t+3.
- Load (lat 2) issued in cycle t: a dependent stalls in t+1 and sees sel 1 in t+2.
- Reset (i_rst_n = 0, asynchronous): all entries go to REG with cnt 0 and lane 0. Outputs during reset:
  - o_ack = i_issue_valid.
  - o_stall = 0.
  - o_fwd_sel = 0 and o_fwd_lane = 0.
  - The stall counter is 0.
- Reset deasserted mid-sequence: all pending hazards are lost by design.

## Configuration
- HAZARD_SB_STALL_CNT_EN:
  - Defined: adds output o_stall_cycles (32-bit). It is cleared by reset and increments on every edge where o_stall = 1, saturating at 32'hFFFF_FFFF.
  - Undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- After reset, lane0 issues rd=5 lat=1 in t0 and lane0 reads rs1=5 in t1, t2, t3. Required: ack=1 throughout; sel 1, 2, 0 in t1, t2, t3; fwd_lane 0 for the sel 1 and sel 2 cycles.
- Lane0 issues rd=8 lat=2 (load) in t0; lane0 reads rs2=8 from t1. Required:
  - t1: o_stall=1, ack=00.
  - t2: ack=01, sel 1.
- Intra-bundle dependency in t0: lane0 writes rd=3 and lane1 reads rs1=3. Required:
  - t0: ack=01, o_stall=1.
  - t1: lane1 re-presented gives ack=10 with sel 1, fwd_lane 0.
- WAW with mixed latency: lane0 writes rd=7 lat=3 in t0, then lane1 writes rd=7 lat=1 in t1. Required: a t2 read of 7 gives sel 1, fwd_lane 1, no stall.
- Flush with a pending write: i_flush=1 in t1 while r9 is WAIT (issued lat=3 in t0). Required:
  - t1: ack=00, o_stall=0.
  - t2: a read of 9 gives sel 0, no stall.
- Build with HAZARD_SB_STALL_CNT_EN and apply 4 stall cycles. Required: o_stall_cycles=4. Asserting i_rst_n=0 mid-stall clears it to 0 immediately.
- Register 0: lane0 writes rd=0 lat=3 and lane1 reads rs1=0 in the same cycle. Required: ack=11, sel 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard with forwarding selects for an in-order multi-lane issue stage.
// Optional build macro HAZARD_SB_STALL_CNT_EN adds the saturating o_stall_cycles counter.
`default_nettype none

module hazard_scoreboard #(
  parameter int AWIDTH  = 5,
  parameter int LANES   = 2,
  parameter int MAX_LAT = 3,
  localparam int NREGS  = 2 ** AWIDTH,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic [LANES-1:0]               i_issue_valid,
  input  logic [LANES-1:0]               i_issue_regwrite,
  input  logic [LANES*AWIDTH-1:0]        i_issue_rd,
  input  logic [LANES*LAT_W-1:0]         i_issue_lat,
  input  logic [LANES*2*AWIDTH-1:0]      i_src_addr,
`ifdef HAZARD_SB_STALL_CNT_EN
  output logic [31:0]                    o_stall_cycles,
`endif
  output logic [LANES-1:0]               o_ack,
  output logic                           o_stall,
  output logic [LANES*2*2-1:0]           o_fwd_sel,
  output logic [LANES*2*LANE_W-1:0]      o_fwd_lane
);

  typedef enum logic [1:0] {
    ST_REG   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXMEM = 2'd2,
    ST_MEMWB = 2'd3
  } state_t;

  state_t            st_q   [NREGS];
  state_t            st_d   [NREGS];
  logic [LAT_W-1:0]  cnt_q  [NREGS];
  logic [LAT_W-1:0]  cnt_d  [NREGS];
  logic [LANE_W-1:0] lane_q [NREGS];
  logic [LANE_W-1:0] lane_d [NREGS];

  logic [LANES-1:0]          ack;
  logic                      stall;
  logic [LANES*4-1:0]        sel;
  logic [LANES*2*LANE_W-1:0] flane;

  logic              blocked;
  logic              rdy;
  logic [AWIDTH-1:0] addr;
  logic [1:0]        tsel  [2];
  logic [LANE_W-1:0] tlane [2];

  // Issue side: lanes are resolved in order so a lower lane's ack is known
  // before a higher lane checks it for an intra-bundle RAW.
  always_comb begin
    blocked  = i_flush;
    ack      = '0;
    sel      = '0;
    flane    = '0;
    rdy      = 1'b0;
    addr     = '0;
    tsel[0]  = 2'd0;
    tsel[1]  = 2'd0;
    tlane[0] = '0;
    tlane[1] = '0;
    for (int k = 0; k < LANES; k++) begin
      rdy = 1'b1;
      for (int s = 0; s < 2; s++) begin
        addr     = i_src_addr[(2*k+s)*AWIDTH +: AWIDTH];
        tsel[s]  = 2'd0;
        tlane[s] = '0;
        if (addr != '0) begin
          if (st_q[addr] == ST_WAIT) rdy = 1'b0;
          for (int j = 0; j < LANES; j++) begin
            if (j < k && ack[j] && i_issue_regwrite[j] &&
                i_issue_rd[j*AWIDTH +: AWIDTH] == addr)
              rdy = 1'b0;
          end
          case (st_q[addr])
            ST_EXMEM: begin tsel[s] = 2'd1; tlane[s] = lane_q[addr]; end
            ST_MEMWB: begin tsel[s] = 2'd2; tlane[s] = lane_q[addr]; end
            default:  ;
          endcase
        end
      end
      ack[k] = i_issue_valid[k] & ~blocked & rdy;
      if (ack[k]) begin
        for (int s = 0; s < 2; s++) begin
          sel[(2*k+s)*2 +: 2]           = tsel[s];
          flane[(2*k+s)*LANE_W +: LANE_W] = tlane[s];
        end
      end
      blocked = blocked | (i_issue_valid[k] & ~ack[k]);
    end
    stall = ~i_flush & (|(i_issue_valid & ~ack));
  end

  assign o_ack      = i_rst_n ? ack : i_issue_valid;
  assign o_stall    = i_rst_n & stall;
  assign o_fwd_sel  = i_rst_n ? sel : '0;
  assign o_fwd_lane = i_rst_n ? flane : '0;

  int unsigned lv;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    lane_d = lane_q;
    lv     = 0;
    for (int r = 0; r < NREGS; r++) begin
      case (st_q[r])
        ST_WAIT: begin
          if (i_flush) begin
            st_d[r]  = ST_REG;
            cnt_d[r] = '0;
          end else if (cnt_q[r] > LAT_W'(1)) begin
            cnt_d[r] = cnt_q[r] - LAT_W'(1);
          end else begin
            st_d[r]  = ST_EXMEM;
            cnt_d[r] = '0;
          end
        end
        ST_EXMEM: st_d[r] = ST_MEMWB;
        ST_MEMWB: st_d[r] = ST_REG;
        default:  ;
      endcase
    end
    // Ascending lane order lets the highest accepted lane win a shared rd.
    for (int k = 0; k < LANES; k++) begin
      if (ack[k] && i_issue_regwrite[k] && i_issue_rd[k*AWIDTH +: AWIDTH] != '0) begin
        lv = int'(i_issue_lat[k*LAT_W +: LAT_W]);
        if (lv == 0) lv = 1;
        else if (lv > MAX_LAT) lv = MAX_LAT;
        if (lv == 1) begin
          st_d[i_issue_rd[k*AWIDTH +: AWIDTH]]  = ST_EXMEM;
          cnt_d[i_issue_rd[k*AWIDTH +: AWIDTH]] = '0;
        end else begin
          st_d[i_issue_rd[k*AWIDTH +: AWIDTH]]  = ST_WAIT;
          cnt_d[i_issue_rd[k*AWIDTH +: AWIDTH]] = LAT_W'(lv - 1);
        end
        lane_d[i_issue_rd[k*AWIDTH +: AWIDTH]] = LANE_W'(k);
      end
    end
    st_d[0]   = ST_REG;
    cnt_d[0]  = '0;
    lane_d[0] = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= '{default: ST_REG};
      cnt_q  <= '{default: '0};
      lane_q <= '{default: '0};
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
    end
  end

`ifdef HAZARD_SB_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
    end else if (o_stall && o_stall_cycles != 32'hFFFF_FFFF) begin
      o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus queues expected responses, a negedge monitor pops and compares.
`default_nettype none

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] valid = '0;
  logic [1:0] regwrite = '0;
  logic [9:0] rd = '0;
  logic [3:0] lat = '0;
  logic [19:0] src = '0;
  logic [1:0] ack;
  logic       stall;
  logic [7:0] sel;
  logic [3:0] flane;
`ifdef HAZARD_SB_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.AWIDTH(5), .LANES(2), .MAX_LAT(3)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_flush          (flush),
    .i_issue_valid    (valid),
    .i_issue_regwrite (regwrite),
    .i_issue_rd       (rd),
    .i_issue_lat      (lat),
    .i_src_addr       (src),
`ifdef HAZARD_SB_STALL_CNT_EN
    .o_stall_cycles   (stall_cycles),
`endif
    .o_ack            (ack),
    .o_stall          (stall),
    .o_fwd_sel        (sel),
    .o_fwd_lane       (flane)
  );

  typedef struct {
    string      name;
    logic [1:0] ack;
    logic       stall;
    logic [7:0] sel;
    logic [3:0] lane;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle. Select/lane
  // fields are only meaningful for lanes expected to be accepted.
  initial begin
    exp_t e;
    logic [7:0] sm;
    logic [3:0] lm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        sm = {{4{e.ack[1]}}, {4{e.ack[0]}}};
        lm = {{2{e.ack[1]}}, {2{e.ack[0]}}};
        check({e.name, ".ack"},   32'(ack),   32'(e.ack));
        check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
        check({e.name, ".sel"},   32'(sel & sm),   32'(e.sel & sm));
        check({e.name, ".lane"},  32'(flane & lm), 32'(e.lane & lm));
      end
    end
  end

  // Sources ordered {lane1 rs2, lane1 rs1, lane0 rs2, lane0 rs1}.
  task automatic cyc(input string nm, input logic [1:0] v, input logic [1:0] rw,
                     input logic [4:0] rd1, input logic [4:0] rd0,
                     input logic [1:0] lt1, input logic [1:0] lt0,
                     input logic [4:0] a1s2, input logic [4:0] a1s1,
                     input logic [4:0] a0s2, input logic [4:0] a0s1,
                     input logic fl, input logic [1:0] eack, input logic est,
                     input logic [7:0] esel, input logic [3:0] eln);
    exp_t e;
    valid    = v;
    regwrite = rw;
    rd       = {rd1, rd0};
    lat      = {lt1, lt0};
    src      = {a1s2, a1s1, a0s2, a0s1};
    flush    = fl;
    e.name = nm; e.ack = eack; e.stall = est; e.sel = esel; e.lane = eln;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc("idle", 2'b00, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,
          2'b00, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset: acks follow valid, no stall, selects zero, pending writes ignored.
    cyc("rst0", 2'b11, 2'b11, 5'd5, 5'd5, 2'd1, 2'd1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 2'b11, 1'b0, 8'h00, 4'h0);
    cyc("rst1", 2'b11, 2'b11, 5'd5, 5'd5, 2'd1, 2'd1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0, 2'b11, 1'b0, 8'h00, 4'h0);
    rst_n = 1'b1;
    idle(1);

    // ALU producer: sel 1, 2, 0 on consecutive cycles.
    cyc("alu_t0", 2'b01, 2'b01, 5'd0, 5'd5, 2'd0, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("alu_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 2'b01, 1'b0, 8'h01, 4'h0);
    cyc("alu_t2", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 2'b01, 1'b0, 8'h02, 4'h0);
    cyc("alu_t3", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);

    // Load-use on rs2.
    cyc("ld_t0", 2'b01, 2'b01, 5'd0, 5'd8, 2'd0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("ld_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
    cyc("ld_t2", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 2'b01, 1'b0, 8'h04, 4'h0);
    idle(2);

    // Intra-bundle RAW.
    cyc("intra_t0", 2'b11, 2'b01, 5'd0, 5'd3, 2'd0, 2'd1, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'b01, 1'b1, 8'h00, 4'h0);
    cyc("intra_t1", 2'b10, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 8'h10, 4'h0);
    idle(2);

    // WAW: short-latency newer write overrides the pending long one.
    cyc("waw_t0", 2'b01, 2'b01, 5'd0, 5'd7, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("waw_t1", 2'b10, 2'b10, 5'd7, 5'd0, 2'd1, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 1'b0, 8'h00, 4'h0);
    cyc("waw_t2", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 2'b01, 1'b0, 8'h01, 4'h1);
    idle(2);

    // Flush clears the pending write.
    cyc("fl_t0", 2'b01, 2'b01, 5'd0, 5'd9, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("fl_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0, 8'h00, 4'h0);
    cyc("fl_t2", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);

    // Register 0 is never a hazard.
    cyc("r0", 2'b11, 2'b01, 5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 1'b0, 8'h00, 4'h0);
    // Latency 0 behaves as 1.
    cyc("lat0_t0", 2'b01, 2'b01, 5'd0, 5'd10, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("lat0_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd10, 5'd0, 1'b0, 2'b01, 1'b0, 8'h04, 4'h0);
    // Same rd on both lanes: lane 1 wins.
    cyc("dup_t0", 2'b11, 2'b11, 5'd12, 5'd12, 2'd1, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b11, 1'b0, 8'h00, 4'h0);
    cyc("dup_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd12, 1'b0, 2'b01, 1'b0, 8'h01, 4'h1);
    // A stalled lane 0 blocks a ready lane 1.
    cyc("blk_t0", 2'b01, 2'b01, 5'd0, 5'd13, 2'd0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("blk_t1", 2'b11, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd13, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
    cyc("blk_t2", 2'b11, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd13, 1'b0, 2'b11, 1'b0, 8'h01, 4'h0);
    idle(2);

`ifdef HAZARD_SB_STALL_CNT_EN
    check("stall_cnt_pre", stall_cycles, 32'd3);
`endif
    rst_n = 1'b0;
    #1;
`ifdef HAZARD_SB_STALL_CNT_EN
    check("stall_cnt_rst", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Four stall cycles from two lat-3 producers.
    cyc("sc_t0", 2'b01, 2'b01, 5'd0, 5'd14, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("sc_t1", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd14, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
    cyc("sc_t2", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd14, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
    cyc("sc_t3", 2'b11, 2'b10, 5'd15, 5'd0, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 5'd14, 1'b0, 2'b11, 1'b0, 8'h01, 4'h0);
    cyc("sc_t4", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd15, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
    cyc("sc_t5", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd15, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);
`ifdef HAZARD_SB_STALL_CNT_EN
    check("stall_cnt_4", stall_cycles, 32'd4);
`endif
    cyc("sc_t6", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd15, 1'b0, 2'b01, 1'b0, 8'h01, 4'h1);
    cyc("sc_t7", 2'b01, 2'b01, 5'd0, 5'd16, 2'd0, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 1'b0, 8'h00, 4'h0);
    cyc("sc_t8", 2'b01, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd16, 1'b0, 2'b00, 1'b1, 8'h00, 4'h0);

    // Reset asserted while the read of r16 is still stalling.
    rst_n = 1'b0;
    #1;
    check("midrst.ack", 32'(ack), 32'h1);
    check("midrst.stall", 32'(stall), 32'h0);
    check("midrst.sel", 32'(sel), 32'h0);
`ifdef HAZARD_SB_STALL_CNT_EN
    check("stall_cnt_midrst", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = 2'b00;
    #1;
    check("post_rst.sel", 32'(sel), 32'h0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
